// File: rtl/port_bus_master.sv
// port_bus_master
//   Hardware initiator for the MCU port I/O bus. Accepts read/write commands
//   and turns each one into a port_id/out_port/io_strb bus cycle. Reads
//   capture in_port and return it as a response.
//
//   A write walks SETUP -> STROBE -> HOLD -> IDLE. A read walks
//   SETUP -> RESP -> IDLE. A 4-bit down-counter times each phase.
//   io_strb is asserted only for writes.
//
// Parameters
//   SETUP_CYC  : cycles the bus is stable before the strobe, or before the
//                read sample (1..15)
//   STROBE_CYC : io_strb high cycles per write (1..15)
//   HOLD_CYC   : cycles the bus is held after the strobe falls (0..15)
//
// Optional build macro
//   PORT_BUS_CMD_FIFO_EN : places a 2-entry command FIFO in front of the FSM.
//                          In that build, cmd_ready means "FIFO not full".
//
// Ports
//   clk, reset            : clock (rising edge); synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_write             : 1 = write (OUT), 0 = read (IN)
//   cmd_port_id/cmd_wdata : target port and write data
//   rsp_valid/rsp_ready   : read-response handshake
//   rsp_rdata             : captured in_port value
//   port_id/out_port      : bus address and bus write data
//   io_strb               : bus write strobe
//   in_port               : bus read data (combinational from port_id)
//   busy                  : FSM is outside IDLE
module port_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_port_id,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  output logic       io_strb,
  input  logic [7:0] in_port,
  output logic       busy
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       wr_q;

  // Command source seen by the FSM: the raw port, or the FIFO head.
  logic       src_valid;
  logic       src_write;
  logic [7:0] src_port;
  logic [7:0] src_data;
  logic       take;

  assign take = (state == S_IDLE) && src_valid;
  assign busy = (state != S_IDLE);

`ifdef PORT_BUS_CMD_FIFO_EN
  logic [16:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_cnt;
  logic        push;

  // Ready depends only on occupancy. A push and a pop can never collide
  // on a full FIFO, because ready is low whenever the FIFO is full.
  assign cmd_ready = (fifo_cnt != 2'd2);
  assign push      = cmd_valid && cmd_ready;
  assign src_valid = (fifo_cnt != 2'd0);
  assign {src_write, src_port, src_data} = fifo_mem[rd_ptr];

  // NOTE: storage carries no reset. Entries are only read when fifo_cnt
  // says they are valid, so clearing the pointers and count is enough.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_write, cmd_port_id, cmd_wdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (take) rd_ptr <= ~rd_ptr;
      case ({push, take})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  assign cmd_ready = (state == S_IDLE);
  assign src_valid = cmd_valid;
  assign src_write = cmd_write;
  assign src_port  = cmd_port_id;
  assign src_data  = cmd_wdata;
`endif

  // NOTE: every state register is assigned with <=, so all of them update
  // together from the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      port_id   <= 8'h00;
      out_port  <= 8'h00;
      io_strb   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            state    <= S_SETUP;
            cnt      <= SETUP_LD;
            wr_q     <= src_write;
            port_id  <= src_port;
            out_port <= src_write ? src_data : 8'h00;
          end
        end

        S_SETUP: begin
          if (cnt == 4'd1) begin
            if (wr_q) begin
              state   <= S_STROBE;
              cnt     <= STROBE_LD;
              io_strb <= 1'b1;
            end else begin
              // Last setup edge: in_port is settled on port_id, so sample it.
              state     <= S_RESP;
              rsp_rdata <= in_port;
              rsp_valid <= 1'b1;
              port_id   <= 8'h00;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_STROBE: begin
          if (cnt == 4'd1) begin
            io_strb <= 1'b0;
            if (HOLD_CYC == 0) begin
              state    <= S_IDLE;
              port_id  <= 8'h00;
              out_port <= 8'h00;
            end else begin
              state <= S_HOLD;
              cnt   <= HOLD_LD;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_HOLD: begin
          if (cnt == 4'd1) begin
            state    <= S_IDLE;
            port_id  <= 8'h00;
            out_port <= 8'h00;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
